// File: rtl/neuron_pkg.sv
// Shared neuron datapath types: activation word, layer vector and collector FSM states.
package neuron_pkg;
  localparam int WORD_W  = 32;
  localparam int LAYER_N = 32;

  typedef logic [WORD_W-1:0] word_t;
  typedef word_t [LAYER_N-1:0] vec_t;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    HOLD = 1'b1
  } coll_state_e;
endpackage

// File: rtl/collector_bank.sv
// One N_OUT-slot activation bank. Slots are written in order, and the write index is the fill count.
// A clear takes priority over a write in the same cycle. The caller never writes when the bank is full.
module collector_bank #(
  parameter int N_OUT = 32,
  parameter int WIDTH = 32,
  localparam int IDX_W = $clog2(N_OUT)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        wr_en_i,
  input  logic [WIDTH-1:0]            wr_dat_i,
  input  logic                        clr_i,
  output logic [N_OUT-1:0][WIDTH-1:0] slots_o,
  output logic [IDX_W:0]              cnt_o,
  output logic                        full_o
);
  logic [N_OUT-1:0][WIDTH-1:0] slots_q, slots_d;
  logic [IDX_W:0]              cnt_q, cnt_d;
  logic [IDX_W-1:0]            idx;

  assign idx = cnt_q[IDX_W-1:0];

  always_comb begin
    slots_d = slots_q;
    cnt_d   = cnt_q;
    if (clr_i) begin
      slots_d = '0;
      cnt_d   = '0;
    end else if (wr_en_i) begin
      slots_d[idx] = wr_dat_i;
      cnt_d        = cnt_q + (IDX_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slots_q <= '0;
      cnt_q   <= '0;
    end else begin
      slots_q <= slots_d;
      cnt_q   <= cnt_d;
    end
  end

  assign slots_o = slots_q;
  assign cnt_o   = cnt_q;
  assign full_o  = (cnt_q == (IDX_W+1)'(N_OUT));
endmodule

// File: rtl/neuron_output_collector.sv
// Packs N_OUT accepted activations into one vector. vec_valid rises 1 cycle after the last beat or after a flush.
// The base build stalls input while a vector is held. COLLECTOR_DBUF_EN adds ping-pong banks that keep filling while a vector is held.
module neuron_output_collector
  import neuron_pkg::*;
#(
  parameter int N_OUT = LAYER_N,
  parameter int WIDTH = WORD_W,
  localparam int IDX_W = $clog2(N_OUT)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WIDTH-1:0]            in_data,
  input  logic                        flush,
  output logic                        vec_valid,
  input  logic                        vec_ready,
  output logic [N_OUT-1:0][WIDTH-1:0] vec_data,
  output logic [IDX_W:0]              fill_count
);
  logic           accept;
  logic           cmpl;
  logic [IDX_W:0] cnt;
  logic           full;

  assign accept = in_valid && in_ready;
  // A flush closes the bank only if the bank then holds at least one beat.
  assign cmpl = in_ready && ((accept && cnt == (IDX_W+1)'(N_OUT-1)) ||
                             (flush && (in_valid || cnt != '0)));

`ifdef COLLECTOR_DBUF_EN
  logic                        fsel_q, fsel_d;
  logic [1:0]                  done_q, done_d;
  logic                        vld_q, vld_d;
  logic [N_OUT-1:0][WIDTH-1:0] vec_q, vec_d;
  logic [N_OUT-1:0][WIDTH-1:0] slots_b [2];
  logic [IDX_W:0]              cnt_b [2];
  logic [1:0]                  full_b, wr_en, clr;
  logic                        out_free, ld, ld_sel;
  logic [IDX_W-1:0]            idx;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    collector_bank #(.N_OUT(N_OUT), .WIDTH(WIDTH)) u_bank (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en_i  (wr_en[b]),
      .wr_dat_i (in_data),
      .clr_i    (clr[b]),
      .slots_o  (slots_b[b]),
      .cnt_o    (cnt_b[b]),
      .full_o   (full_b[b])
    );
  end

  assign cnt      = cnt_b[fsel_q];
  assign full     = full_b[fsel_q];
  assign idx      = cnt[IDX_W-1:0];
  assign in_ready = !done_q[fsel_q] && !full;
  assign out_free = !vld_q || vec_ready;
  assign ld       = out_free && (done_q != 2'b00 || cmpl);
  // If both banks are closed, fsel points at the older one. If only one is closed, it is the other bank.
  assign ld_sel   = (done_q != 2'b00 && !done_q[fsel_q]) ? ~fsel_q : fsel_q;

  always_comb begin
    wr_en  = '0;
    clr    = '0;
    done_d = done_q;
    fsel_d = fsel_q;
    vld_d  = vld_q;
    vec_d  = vec_q;
    if (accept) wr_en[fsel_q] = 1'b1;
    if (cmpl) begin
      done_d[fsel_q] = 1'b1;
      fsel_d         = ~fsel_q;
    end
    if (ld) begin
      clr[ld_sel]    = 1'b1;
      done_d[ld_sel] = 1'b0;
      vld_d          = 1'b1;
      vec_d          = slots_b[ld_sel];
      // Bypass the beat that completes the bank, so the vector appears next cycle.
      if (accept && ld_sel == fsel_q) vec_d[idx] = in_data;
    end else if (vec_ready) begin
      vld_d = 1'b0;
      vec_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsel_q <= 1'b0;
      done_q <= '0;
      vld_q  <= 1'b0;
      vec_q  <= '0;
    end else begin
      fsel_q <= fsel_d;
      done_q <= done_d;
      vld_q  <= vld_d;
      vec_q  <= vec_d;
    end
  end

  assign vec_valid  = vld_q;
  assign vec_data   = vec_q;
  assign fill_count = done_q[fsel_q] ? '0 : cnt;
`else
  coll_state_e state_q, state_d;

  collector_bank #(.N_OUT(N_OUT), .WIDTH(WIDTH)) u_bank (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en_i  (accept),
    .wr_dat_i (in_data),
    .clr_i    (vec_valid && vec_ready),
    .slots_o  (vec_data),
    .cnt_o    (cnt),
    .full_o   (full)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL:    if (cmpl) state_d = HOLD;
      HOLD:    if (vec_ready) state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= FILL;
    else        state_q <= state_d;
  end

  assign in_ready   = (state_q == FILL) && !full;
  assign vec_valid  = (state_q == HOLD);
  assign fill_count = cnt;
`endif
endmodule

// File: tb/tb_neuron_output_collector.sv
// Directed and random bench for neuron_output_collector, using a queue-based reference model.
module tb_neuron_output_collector;
  localparam int N = 32;
  localparam int W = 32;
`ifdef COLLECTOR_DBUF_EN
  localparam bit DBUF = 1'b1;
`else
  localparam bit DBUF = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [W-1:0]        in_data = '0;
  logic                flush = 1'b0;
  logic                vec_valid;
  logic                vec_ready = 1'b0;
  logic [N-1:0][W-1:0] vec_data;
  logic [5:0]          fill_count;

  int errors = 0;
  int checks = 0;
  int delivered = 0;
  int dut_hs = 0;

  // Model: beats in the filling bank, closed vectors waiting, and the vector presented downstream.
  logic [W-1:0]        m_beats[$];
  logic [N-1:0][W-1:0] m_wait[$];
  logic                m_vld = 1'b0;
  logic [N-1:0][W-1:0] m_out = '0;

  always #5 clk = ~clk;

  neuron_output_collector dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .flush      (flush),
    .vec_valid  (vec_valid),
    .vec_ready  (vec_ready),
    .vec_data   (vec_data),
    .fill_count (fill_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_vec(input string tag, input logic [N-1:0][W-1:0] exp);
    int bad;
    checks++;
    assert (vec_data === exp) else begin
      errors++;
      bad = 0;
      for (int k = N-1; k >= 0; k--) if (vec_data[k] !== exp[k]) bad = k;
      $error("FAIL %s slot %0d: got %h expected %h", tag, bad, vec_data[bad], exp[bad]);
    end
  endtask

  function automatic logic [N-1:0][W-1:0] pack_beats();
    logic [N-1:0][W-1:0] v;
    v = '0;
    foreach (m_beats[i]) v[i] = m_beats[i];
    return v;
  endfunction

  function automatic logic exp_in_ready();
    if (DBUF) return m_wait.size() < 2;
    return !m_vld;
  endfunction

  task automatic model_edge(input logic v, input logic [W-1:0] d, input logic f, input logic r);
    logic                rdy, cmpl, free;
    logic [N-1:0][W-1:0] nv;
    rdy  = exp_in_ready();
    cmpl = 1'b0;
    nv   = '0;
    if (DBUF) begin
      free = !m_vld || r;
      if (rdy) begin
        if (v) m_beats.push_back(d);
        if (m_beats.size() == N || (f && m_beats.size() > 0)) begin
          cmpl = 1'b1;
          nv   = pack_beats();
          m_beats.delete();
        end
      end
      if (m_vld && r) delivered++;
      if (free && m_wait.size() > 0) begin
        m_out = m_wait.pop_front();
        m_vld = 1'b1;
      end else if (free && cmpl) begin
        m_out = nv;
        m_vld = 1'b1;
        cmpl  = 1'b0;
      end else if (r) begin
        m_vld = 1'b0;
        m_out = '0;
      end
      if (cmpl) m_wait.push_back(nv);
    end else if (m_vld) begin
      if (r) begin
        m_vld = 1'b0;
        m_beats.delete();
        delivered++;
      end
    end else begin
      if (v) m_beats.push_back(d);
      if (m_beats.size() == N || (f && m_beats.size() > 0)) begin
        m_vld = 1'b1;
        m_out = pack_beats();
      end
    end
  endtask

  // Called at a negedge: drive inputs, compare the current state, then advance one clock.
  task automatic cycle(input logic v, input logic [W-1:0] d, input logic f, input logic r);
    in_valid  = v;
    in_data   = d;
    flush     = f;
    vec_ready = r;
    chk("in_ready", {31'd0, in_ready}, {31'd0, exp_in_ready()});
    chk("vec_valid", {31'd0, vec_valid}, {31'd0, m_vld});
    chk("fill_count", {26'd0, fill_count}, m_beats.size());
    if (m_vld) chk_vec("vec_data", m_out);
    if (vec_valid === 1'b1 && r) dut_hs++;
    @(posedge clk);
    model_edge(v, d, f, r);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    flush     = 1'b0;
    vec_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    m_beats.delete();
    m_wait.delete();
    m_vld = 1'b0;
    m_out = '0;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_vec_valid", {31'd0, vec_valid}, 32'd0);
    chk("rst_fill_count", {26'd0, fill_count}, 32'd0);
    chk_vec("rst_vec_data", '0);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [N-1:0][W-1:0] ev;
    int start;
    @(negedge clk);
    do_reset();

    // Full vector with held output
    for (int k = 0; k < N; k++) begin
      ev[k] = W'(k) * 32'h3fffffff;
      cycle(1'b1, W'(k) * 32'h3fffffff, 1'b0, 1'b0);
    end
    chk("full_vld_latency", {31'd0, vec_valid}, 32'd1);
    chk_vec("full_vec", ev);
    cycle(1'b0, '0, 1'b1, 1'b0);
    repeat (4) cycle(!DBUF, 32'hdeadbeef, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b1);
    chk("hs_vec_valid", {31'd0, vec_valid}, 32'd0);
    chk_vec("hs_cleared", '0);
    cycle(1'b0, '0, 1'b1, 1'b0);

    // Flush after 7 beats without a beat, then with the 8th beat
    for (int k = 1; k <= 7; k++) cycle(1'b1, W'(k), 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    ev = '0;
    for (int k = 0; k < 7; k++) ev[k] = W'(k + 1);
    chk("flush7_vld", {31'd0, vec_valid}, 32'd1);
    chk_vec("flush7_vec", ev);
    cycle(1'b0, '0, 1'b0, 1'b1);
    for (int k = 1; k <= 7; k++) cycle(1'b1, W'(k), 1'b0, 1'b0);
    cycle(1'b1, 32'd8, 1'b1, 1'b0);
    ev[7] = 32'd8;
    chk("flush8_vld", {31'd0, vec_valid}, 32'd1);
    chk_vec("flush8_vec", ev);
    cycle(1'b0, '0, 1'b0, 1'b1);

    // Random gaps, downstream always ready
    start = dut_hs;
    begin
      int target;
      target = delivered + 3;
      for (int c = 0; c < 2000 && delivered < target; c++)
        cycle(1'($urandom_range(0, 1)), $urandom, 1'b0, 1'b1);
    end
    chk("rand_vectors", dut_hs - start, 32'd3);

    // Reset mid-fill, then a clean vector
    do_reset();
    for (int k = 0; k < 10; k++) cycle(1'b1, $urandom, 1'b0, 1'b0);
    do_reset();
    for (int k = 0; k < N; k++) begin
      ev[k] = $urandom;
      cycle(1'b1, ev[k], 1'b0, 1'b0);
    end
    chk("post_rst_vld", {31'd0, vec_valid}, 32'd1);
    chk_vec("post_rst_vec", ev);
    cycle(1'b0, '0, 1'b0, 1'b1);

    if (DBUF) begin
      // Continuous input across two vectors with late downstream ready
      do_reset();
      start = dut_hs;
      for (int b = 0; b < 2 * N; b++) begin
        chk("dbuf_in_ready", {31'd0, in_ready}, 32'd1);
        cycle(1'b1, W'(b + 100), 1'b0, b >= 40);
      end
      repeat (4) cycle(1'b0, '0, 1'b0, 1'b1);
      chk("dbuf_vectors", dut_hs - start, 32'd2);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/neuron_output_collector.md
Name: neuron_output_collector

Overview:
- Sits directly downstream of the neuron threshold stage.
- Captures one 32-bit activation per accepted beat and packs N of them into a vector shaped like the packed [N-1:0][WIDTH-1:0] input of the next layer's multiplier stage.
- Presents the completed vector to the next layer with a valid/ready handshake.
- Turns the single-output neuron into a layer-to-layer link.

Parameters:
- N_OUT, 32, number of activations per output vector
- WIDTH, 32, bits per activation
- IDX_W, $clog2(N_OUT), slot index width (derived, not overridden)

Ports:
- clk  input  1  clock; all logic on posedge
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  activation beat valid from threshold stage
- in_ready  output  1  collector can accept a beat this cycle
- in_data  input  WIDTH  activation value
- flush  input  1  emit partially filled vector early; sampled with or without in_valid
- vec_valid  output  1  vec_data holds a complete vector
- vec_ready  input  1  next layer consumes vector
- vec_data  output  [N_OUT-1:0][WIDTH]  packed vector; slot k = k-th accepted beat
- fill_count  output  IDX_W+1  number of slots written in the filling bank

Behaviour:
- Reset (rst_n=0 at posedge):
  - state=FILL, write index=0, fill_count=0
  - in_ready=1 after reset, vec_valid=0, vec_data=all zeros
- States:
  - FILL
    - in_ready=1.
    - Beat accepted when in_valid&in_ready: slot[idx]<=in_data, idx++, fill_count++.
    - Accepting the beat into slot N_OUT-1 -> HOLD next cycle, vec_valid=1, idx=0.
    - Latency: last beat to vec_valid is exactly 1 cycle.
  - HOLD
    - vec_valid=1, vec_data stable, in_ready=0 (base build).
    - vec_valid&vec_ready -> FILL next cycle, all slots cleared to 0, fill_count=0.
- Flush:
  - In FILL with fill_count>0, flush=1 -> HOLD next cycle; unwritten slots stay 0.
  - A beat accepted in the same cycle as flush is included, and written before the transition.
  - Flush in FILL with fill_count=0 and no beat: ignored. Empty vectors are never emitted.
  - Flush in HOLD: ignored.
- No overflow possible: in_ready=0 whenever the bank is full.
- vec_valid, once asserted, never drops without vec_ready.
- in_data is ignored when in_valid=0.
- Reset mid-fill or mid-hold discards all data; same state as power-up reset.
- No arithmetic on data. fill_count saturates at N_OUT by construction.

Optional Feature:
- Macro: COLLECTOR_DBUF_EN
- Defined: ping-pong banks.
  - When a bank completes, it moves to the output register while the other bank keeps filling. in_ready stays 1 unless both banks are full.
  - A completion with the output register free gives vec_valid one cycle later; otherwise the completed bank waits.
  - A handshake in the same cycle as the other bank completing loads the new vector next cycle with no bubble.
  - fill_count reflects the filling bank only.
- Undefined: single bank, in_ready=0 during HOLD as above.

Decomposition:
- Shared package neuron_pkg holds:
  - localparam WORD_W=32 and LAYER_N=32
  - typedef word_t (logic [WORD_W-1:0])
  - typedef vec_t (word_t [LAYER_N-1:0])
  - enum coll_state_e {FILL, HOLD}
- One natural sub-module: collector_bank, a single N_OUT-slot register bank with write index, clear, and full flag. It is instantiated once, or twice under COLLECTOR_DBUF_EN.

Test Plan:
- Reset then 32 beats, in_valid=1, in_data=k*32'h3fffffff, vec_ready=0 -> vec_valid=1 one cycle after beat 31; slot k=k*32'h3fffffff; in_ready=0 while held (base build).
- Hold vector 5 cycles, then pulse vec_ready -> vec_valid drops next cycle, fill_count=0, all slots 0, in_ready=1.
- 7 beats with values 1..7, then flush with no beat -> vec_valid next cycle; slots 0..6=1..7, slots 7..31=0. Repeat with flush on beat 7 (value 8) -> slots 0..7=1..8.
- Random in_valid gaps (50%) over 3 vectors with vec_ready=1 -> every vector is the exact ordered beat sequence, none lost or duplicated.
- Assert rst_n=0 after 10 beats -> next posedge: vec_valid=0, fill_count=0, in_ready=1; subsequent 32 beats form a clean vector.
- COLLECTOR_DBUF_EN defined, in_valid=1 continuously for 64 beats, vec_ready held low until beat 40 -> in_ready=1 through beat 63 since banks alternate; two vectors delivered in order; in_ready=0 only while both banks are full.
